// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: four-state run/pause/lap FSM driving a BCD
// mm:ss.cc count from a 10 ms external timebase, with a lap freeze latch
// and control of the external RTC timer (enable and phase realignment).
module stopwatch_ctrl #(
  parameter int MIN_LIMIT = 59
) (
  input  logic       i_sclk,
  input  logic       i_reset,
  input  logic       i_start_stop,
  input  logic       i_lap,
  input  logic       i_clear,
  input  logic       i_base_tick,
  output logic       o_timerenb,
  output logic       o_timer_reset_n,
  output logic [3:0] o_min_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_sec_ones,
  output logic [3:0] o_cs_tens,
  output logic [3:0] o_cs_ones,
  output logic       o_running,
  output logic       o_lap_active,
  output logic       o_rollover
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RUNNING  = 2'd1;
  localparam logic [1:0] S_PAUSED   = 2'd2;
  localparam logic [1:0] S_LAP_HOLD = 2'd3;

  // Digit order: 0 cs_ones, 1 cs_tens, 2 sec_ones, 3 sec_tens,
  // 4 min_ones, 5 min_tens.
  localparam int ND = 6;

  // Minutes limit split into BCD digits for the wrap compare.
  localparam logic [3:0] MIN_TENS = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] MIN_ONES = 4'(MIN_LIMIT % 10);

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       r_tick_q;
  logic       r_rollover;
  logic       r_timer_reset_n;
  logic [3:0] r_live [ND];
  logic [3:0] r_lap  [ND];
  logic [3:0] w_live_inc [ND];
  logic [3:0] w_disp [ND];
  logic [4:0] w_carry;

  logic w_tick;
  logic w_clr;
  logic w_ss;
  logic w_lap;
  logic w_running;
  logic w_lap_active;
  logic w_timerenb;
  logic w_count_en;
  logic w_lap_capture;
  logic w_idle_start;
  logic w_min_at_limit;
  logic w_wrap;

  // Same-cycle priority: clear beats start_stop beats lap; losers are dropped.
  assign w_clr = i_clear;
  assign w_ss  = i_start_stop & ~i_clear;
  assign w_lap = i_lap & ~i_clear & ~i_start_stop;

  // Rising edge of the timebase against its one-cycle delayed copy.
  assign w_tick = i_base_tick & ~r_tick_q;

  // State register.
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; clear overrides every other transition.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ss) w_state_next = S_RUNNING;
      end
      S_RUNNING: begin
        if (w_ss)       w_state_next = S_PAUSED;
        else if (w_lap) w_state_next = S_LAP_HOLD;
      end
      S_PAUSED: begin
        if (w_ss) w_state_next = S_RUNNING;
      end
      S_LAP_HOLD: begin
        if (w_ss)       w_state_next = S_PAUSED;
        else if (w_lap) w_state_next = S_RUNNING;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_clr) w_state_next = S_IDLE;
  end

  // State-derived outputs and control strobes.
  always_comb begin
    w_running     = 1'b0;
    w_lap_active  = 1'b0;
    w_lap_capture = 1'b0;
    w_idle_start  = 1'b0;
    case (r_state)
      S_RUNNING: begin
        w_running     = 1'b1;
        w_lap_capture = w_lap;
      end
      S_LAP_HOLD: begin
        w_running    = 1'b1;
        w_lap_active = 1'b1;
      end
      S_IDLE: begin
        w_idle_start = w_ss;
      end
      default: begin
        w_running = 1'b0;
      end
    endcase
  end

  assign w_timerenb = w_running;

  // A tick coinciding with clear is thrown away.
  assign w_count_en = w_tick & w_running & ~w_clr;

  // Centisecond and second digits: ripple carry, seconds tens tops out at 5.
  assign w_carry[0] = w_count_en;
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_low_digit
      localparam logic [3:0] DMAX = (gi == 3) ? 4'd5 : 4'd9;
      logic w_at_max;
      assign w_at_max = (r_live[gi] == DMAX);
      assign w_carry[gi+1] = w_carry[gi] & w_at_max;
      assign w_live_inc[gi] = !w_carry[gi] ? r_live[gi] :
                              (w_at_max ? 4'd0 : r_live[gi] + 4'd1);
    end
  endgenerate

  // Minutes count to MIN_LIMIT, then the whole count wraps to zero.
  assign w_min_at_limit = (r_live[5] == MIN_TENS) && (r_live[4] == MIN_ONES);
  assign w_wrap         = w_carry[4] & w_min_at_limit;

  // Minute digit update, including the full-count wrap.
  always_comb begin
    w_live_inc[4] = r_live[4];
    w_live_inc[5] = r_live[5];
    if (w_carry[4]) begin
      if (w_min_at_limit) begin
        w_live_inc[4] = 4'd0;
        w_live_inc[5] = 4'd0;
      end else if (r_live[4] == 4'd9) begin
        w_live_inc[4] = 4'd0;
        w_live_inc[5] = r_live[5] + 4'd1;
      end else begin
        w_live_inc[4] = r_live[4] + 4'd1;
      end
    end
  end

  // Timebase edge-detect register.
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      r_tick_q <= 1'b0;
    end else begin
      r_tick_q <= i_base_tick;
    end
  end

  // Live count: cleared on clear, otherwise takes the incremented value.
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < ND; i++) r_live[i] <= 4'd0;
    end else if (w_clr) begin
      for (int i = 0; i < ND; i++) r_live[i] <= 4'd0;
    end else begin
      for (int i = 0; i < ND; i++) r_live[i] <= w_live_inc[i];
    end
  end

  // Lap latch: snapshot of the live count taken on entry to lap hold.
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < ND; i++) r_lap[i] <= 4'd0;
    end else if (w_clr) begin
      for (int i = 0; i < ND; i++) r_lap[i] <= 4'd0;
    end else if (w_lap_capture) begin
      for (int i = 0; i < ND; i++) r_lap[i] <= r_live[i];
    end
  end

  // One-cycle wrap pulse, aligned with the count showing 00:00.00.
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      r_rollover <= 1'b0;
    end else begin
      r_rollover <= w_wrap;
    end
  end

  // RTC timer reset: low one cycle after clear or a fresh start from idle.
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      r_timer_reset_n <= 1'b0;
    end else begin
      r_timer_reset_n <= ~(w_clr | w_idle_start);
    end
  end

  // Display source switches with the state, so leaving lap hold is immediate.
  generate
    for (genvar gi = 0; gi < ND; gi++) begin : g_disp
      assign w_disp[gi] = w_lap_active ? r_lap[gi] : r_live[gi];
    end
  endgenerate

  assign o_cs_ones       = w_disp[0];
  assign o_cs_tens       = w_disp[1];
  assign o_sec_ones      = w_disp[2];
  assign o_sec_tens      = w_disp[3];
  assign o_min_ones      = w_disp[4];
  assign o_min_tens      = w_disp[5];
  assign o_running       = w_running;
  assign o_lap_active    = w_lap_active;
  assign o_timerenb      = w_timerenb;
  assign o_rollover      = r_rollover;
  assign o_timer_reset_n = r_timer_reset_n;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a default-limit instance for the FSM,
// lap and pause behaviour, and a MIN_LIMIT=1 instance for wrap timing.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_ss, a_lap, a_clr, a_tick;
  logic b_ss, b_lap, b_clr, b_tick;

  logic       a_en, a_trn, a_run, a_lapact, a_ro;
  logic [3:0] a_mt, a_mo, a_st, a_so, a_ct, a_co;
  logic       b_en, b_trn, b_run, b_lapact, b_ro;
  logic [3:0] b_mt, b_mo, b_st, b_so, b_ct, b_co;

  stopwatch_ctrl dut_a (
    .i_sclk(clk), .i_reset(rst),
    .i_start_stop(a_ss), .i_lap(a_lap), .i_clear(a_clr), .i_base_tick(a_tick),
    .o_timerenb(a_en), .o_timer_reset_n(a_trn),
    .o_min_tens(a_mt), .o_min_ones(a_mo), .o_sec_tens(a_st), .o_sec_ones(a_so),
    .o_cs_tens(a_ct), .o_cs_ones(a_co),
    .o_running(a_run), .o_lap_active(a_lapact), .o_rollover(a_ro)
  );

  stopwatch_ctrl #(.MIN_LIMIT(1)) dut_b (
    .i_sclk(clk), .i_reset(rst),
    .i_start_stop(b_ss), .i_lap(b_lap), .i_clear(b_clr), .i_base_tick(b_tick),
    .o_timerenb(b_en), .o_timer_reset_n(b_trn),
    .o_min_tens(b_mt), .o_min_ones(b_mo), .o_sec_tens(b_st), .o_sec_ones(b_so),
    .o_cs_tens(b_ct), .o_cs_ones(b_co),
    .o_running(b_run), .o_lap_active(b_lapact), .o_rollover(b_ro)
  );

  localparam int SEL_DISP = 0, SEL_EN = 1, SEL_TRN = 2, SEL_RUN = 3,
                 SEL_LAP = 4, SEL_RO = 5, SEL_DISP_B = 6, SEL_RO_B = 7,
                 SEL_RUN_B = 8;

  string       q_tag[$];
  int          q_sel[$];
  logic [31:0] q_exp[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_DISP:   return {8'h0, a_mt, a_mo, a_st, a_so, a_ct, a_co};
      SEL_EN:     return {31'h0, a_en};
      SEL_TRN:    return {31'h0, a_trn};
      SEL_RUN:    return {31'h0, a_run};
      SEL_LAP:    return {31'h0, a_lapact};
      SEL_RO:     return {31'h0, a_ro};
      SEL_DISP_B: return {8'h0, b_mt, b_mo, b_st, b_so, b_ct, b_co};
      SEL_RO_B:   return {31'h0, b_ro};
      SEL_RUN_B:  return {31'h0, b_run};
      default:    return 32'hdeadbeef;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
    q_tag.push_back(tag);
    q_sel.push_back(sel);
    q_exp.push_back(v);
  endtask

  task automatic check_outputs();
    while (q_tag.size() > 0) begin
      string       t;
      int          s;
      logic [31:0] e;
      logic [31:0] o;
      t = q_tag.pop_front();
      s = q_sel.pop_front();
      e = q_exp.pop_front();
      o = observe(s);
      total++;
      assert (o === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", t, o, e);
      end
      $display("check %s observed=%h expected=%h", t, o, e);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_a(input logic ss, input logic lp, input logic cl);
    a_ss = ss; a_lap = lp; a_clr = cl;
    cycle();
    a_ss = 1'b0; a_lap = 1'b0; a_clr = 1'b0;
  endtask

  task automatic ticks_a(input int n);
    for (int i = 0; i < n; i++) begin
      a_tick = 1'b1; cycle();
      a_tick = 1'b0; cycle();
    end
  endtask

  task automatic ticks_b(input int n);
    for (int i = 0; i < n; i++) begin
      b_tick = 1'b1; cycle();
      b_tick = 1'b0; cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    a_ss = 0; a_lap = 0; a_clr = 0; a_tick = 0;
    b_ss = 0; b_lap = 0; b_clr = 0; b_tick = 0;
    @(negedge clk);
    cycle();

    // Reset state
    expect_val("rst_disp", SEL_DISP, 0);
    expect_val("rst_en",   SEL_EN,   0);
    expect_val("rst_trn",  SEL_TRN,  0);
    expect_val("rst_run",  SEL_RUN,  0);
    expect_val("rst_lap",  SEL_LAP,  0);
    expect_val("rst_ro",   SEL_RO,   0);
    check_outputs();

    rst = 1'b0;
    cycle();
    expect_val("trn_release", SEL_TRN, 1);
    check_outputs();

    // Start from idle realigns the timer, then 123 ticks
    pulse_a(1, 0, 0);
    expect_val("start_trn_low", SEL_TRN, 0);
    expect_val("start_run",     SEL_RUN, 1);
    expect_val("start_en",      SEL_EN,  1);
    check_outputs();
    ticks_a(123);
    expect_val("t123_disp", SEL_DISP, 32'h000123);
    expect_val("t123_en",   SEL_EN,   1);
    expect_val("t123_trn",  SEL_TRN,  1);
    check_outputs();

    // Clear back to idle
    pulse_a(0, 0, 1);
    expect_val("clr_disp", SEL_DISP, 0);
    expect_val("clr_run",  SEL_RUN,  0);
    expect_val("clr_trn",  SEL_TRN,  0);
    check_outputs();

    // Lap freeze and release
    pulse_a(1, 0, 0);
    ticks_a(50);
    expect_val("pre_lap_disp", SEL_DISP, 32'h000050);
    check_outputs();
    pulse_a(0, 1, 0);
    expect_val("lap_active", SEL_LAP, 1);
    expect_val("lap_run",    SEL_RUN, 1);
    check_outputs();
    ticks_a(30);
    expect_val("lap_hold_disp", SEL_DISP, 32'h000050);
    expect_val("lap_hold_en",   SEL_EN,   1);
    check_outputs();
    pulse_a(0, 1, 0);
    expect_val("lap_rel_disp", SEL_DISP, 32'h000080);
    expect_val("lap_rel_flag", SEL_LAP,  0);
    check_outputs();

    // Pause holds the count
    ticks_a(120);
    expect_val("t200_disp", SEL_DISP, 32'h000200);
    check_outputs();
    pulse_a(1, 0, 0);
    expect_val("pause_run", SEL_RUN, 0);
    expect_val("pause_en",  SEL_EN,  0);
    expect_val("pause_trn", SEL_TRN, 1);
    check_outputs();
    ticks_a(10);
    expect_val("paused_disp", SEL_DISP, 32'h000200);
    check_outputs();
    pulse_a(1, 0, 0);
    expect_val("resume_trn", SEL_TRN, 1);
    expect_val("resume_run", SEL_RUN, 1);
    check_outputs();
    ticks_a(5);
    expect_val("t205_disp", SEL_DISP, 32'h000205);
    check_outputs();

    // A tick coinciding with the stop pulse is still counted
    a_ss = 1; a_tick = 1;
    cycle();
    a_ss = 0; a_tick = 0;
    cycle();
    expect_val("stop_tick_disp", SEL_DISP, 32'h000206);
    expect_val("stop_tick_run",  SEL_RUN,  0);
    check_outputs();
    pulse_a(1, 0, 0);

    // Clear, start_stop and tick together while running
    a_clr = 1; a_ss = 1; a_tick = 1;
    cycle();
    a_clr = 0; a_ss = 0; a_tick = 0;
    expect_val("combo_disp", SEL_DISP, 0);
    expect_val("combo_run",  SEL_RUN,  0);
    expect_val("combo_trn",  SEL_TRN,  0);
    check_outputs();
    cycle();
    expect_val("combo_trn_rel", SEL_TRN, 1);
    check_outputs();

    // start_stop beats lap; lap ignored in PAUSED
    pulse_a(1, 0, 0);
    pulse_a(1, 1, 0);
    expect_val("prio_run", SEL_RUN, 0);
    expect_val("prio_lap", SEL_LAP, 0);
    check_outputs();
    pulse_a(0, 1, 0);
    expect_val("paused_lap_ign", SEL_LAP, 0);
    expect_val("paused_lap_run", SEL_RUN, 0);
    check_outputs();

    // LAP_HOLD -> PAUSED shows the live count immediately
    pulse_a(1, 0, 0);
    ticks_a(3);
    pulse_a(0, 1, 0);
    ticks_a(2);
    expect_val("lh_disp", SEL_DISP, 32'h000003);
    check_outputs();
    pulse_a(1, 0, 0);
    expect_val("lh_pause_disp", SEL_DISP, 32'h000005);
    expect_val("lh_pause_lap",  SEL_LAP,  0);
    expect_val("lh_pause_run",  SEL_RUN,  0);
    check_outputs();

    // Asynchronous reset while in lap hold
    pulse_a(1, 0, 0);
    pulse_a(0, 1, 0);
    ticks_a(4);
    rst = 1'b1;
    #1;
    expect_val("arst_disp", SEL_DISP, 0);
    expect_val("arst_run",  SEL_RUN,  0);
    expect_val("arst_lap",  SEL_LAP,  0);
    expect_val("arst_en",   SEL_EN,   0);
    expect_val("arst_trn",  SEL_TRN,  0);
    expect_val("arst_ro",   SEL_RO,   0);
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    cycle();
    expect_val("arst_rel_trn",  SEL_TRN,  1);
    expect_val("arst_rel_disp", SEL_DISP, 0);
    expect_val("arst_rel_ro",   SEL_RO,   0);
    check_outputs();

    // Wrap on the MIN_LIMIT=1 instance
    b_ss = 1; cycle(); b_ss = 0;
    ticks_b(5999);
    expect_val("b_005999", SEL_DISP_B, 32'h005999);
    check_outputs();
    ticks_b(1);
    expect_val("b_010000", SEL_DISP_B, 32'h010000);
    check_outputs();
    ticks_b(5999);
    expect_val("b_015999", SEL_DISP_B, 32'h015999);
    expect_val("b_pre_ro", SEL_RO_B,   0);
    check_outputs();
    b_tick = 1; cycle(); b_tick = 0;
    expect_val("b_wrap_disp", SEL_DISP_B, 0);
    expect_val("b_wrap_ro",   SEL_RO_B,   1);
    check_outputs();
    cycle();
    expect_val("b_ro_clear", SEL_RO_B, 0);
    check_outputs();
    ticks_b(1);
    expect_val("b_after_wrap", SEL_DISP_B, 32'h000001);
    expect_val("b_still_run",  SEL_RUN_B,  1);
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter MIN_LIMIT, default 59: maximum minutes value before wrap; legal range 1..99.
REQ-002 SHALL have port i_sclk  input  1  sole system clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_start_stop  input  1  one-cycle pulse that starts or stops counting.
REQ-005 SHALL have port i_lap  input  1  one-cycle pulse that freezes or releases the display.
REQ-006 SHALL have port i_clear  input  1  one-cycle pulse that zeroes the count.
REQ-007 SHALL have port i_base_tick  input  1  10 ms timebase square wave from the RTC timer; one rising edge equals 10 ms.
REQ-008 SHALL have port o_timerenb  output  1  enable to the RTC timer.
REQ-009 SHALL have port o_timer_reset_n  output  1  active-low reset to the RTC timer.
REQ-010 SHALL have ports o_min_tens, o_min_ones, o_sec_tens, o_sec_ones, o_cs_tens, o_cs_ones  output  4 each  BCD display digits.
REQ-011 SHALL have port o_running  output  1  high in RUNNING or LAP_HOLD.
REQ-012 SHALL have port o_lap_active  output  1  high in LAP_HOLD.
REQ-013 SHALL have port o_rollover  output  1  one-cycle pulse on wrap from max to 00:00.00.

Function
REQ-014 SHALL implement FSM states IDLE, RUNNING, PAUSED, LAP_HOLD.
REQ-015 SHALL prioritise same-cycle inputs as i_clear > i_start_stop > i_lap; lower-priority pulses in that cycle are discarded.
REQ-016 SHALL transition IDLE -start_stop-> RUNNING; RUNNING -start_stop-> PAUSED; PAUSED -start_stop-> RUNNING; RUNNING -lap-> LAP_HOLD; LAP_HOLD -lap-> RUNNING; LAP_HOLD -start_stop-> PAUSED.
REQ-017 SHALL go to IDLE on i_clear from any state, zeroing live count and lap latch on the next edge.
REQ-018 SHALL ignore i_lap in IDLE and PAUSED.
REQ-019 SHALL register i_base_tick every cycle (tick_q) and detect a tick when i_base_tick=1 and tick_q=0.
REQ-020 SHALL increment the live count only on a detected tick while in RUNNING or LAP_HOLD; the new value appears on outputs the cycle after detection.
REQ-021 SHALL count centiseconds 00..99, seconds 00..59 and minutes 00..MIN_LIMIT in BCD, each digit carrying at 9 or at its field limit.
REQ-022 SHALL wrap MIN_LIMIT:59.99 -> 00:00.00 on a tick, assert o_rollover for exactly that one cycle and keep counting.
REQ-023 SHALL drive the display digits from the live count in all states except LAP_HOLD.
REQ-024 SHALL capture the live count into the lap latch on the RUNNING->LAP_HOLD edge and drive the display from the latch while in LAP_HOLD; the live count keeps advancing.
REQ-025 SHALL on leaving LAP_HOLD return the display to the live count in the same cycle the state changes.
REQ-026 SHALL drive o_timerenb high exactly in RUNNING and LAP_HOLD.
REQ-027 SHALL drive o_timer_reset_n low for one cycle after i_clear, and for one cycle on IDLE->RUNNING, realigning the timer phase.
REQ-028 SHALL discard a tick that coincides with i_clear; a tick coinciding with start_stop to PAUSED is counted.

Reset
REQ-029 SHALL on i_reset, asynchronously, force state IDLE, live count, lap latch and tick_q to 0, all digits 0, o_running=0, o_lap_active=0, o_rollover=0, o_timerenb=0 and o_timer_reset_n=0.
REQ-030 SHALL release o_timer_reset_n to 1 on the first clock edge after i_reset deasserts.
REQ-031 SHALL, when reset asserts mid-count or in LAP_HOLD, lose all count and lap data with no further o_rollover.

Verification
REQ-032 SHALL pass: reset, start_stop, 123 base-tick edges -> display 00:01.23, o_timerenb=1.
REQ-033 SHALL pass: at 00:00.50 pulse lap, 30 ticks -> display holds 00:00.50; lap again -> display 00:00.80.
REQ-034 SHALL pass: preload to 59:59.99 via ticks, with MIN_LIMIT=59, one more tick -> 00:00.00 and a one-cycle o_rollover.
REQ-035 SHALL pass: PAUSED at 00:02.00, 10 ticks -> unchanged; start_stop plus 5 ticks -> 00:02.05.
REQ-036 SHALL pass: i_clear, i_start_stop and a tick edge in the same cycle while RUNNING -> IDLE, 00:00.00, o_timer_reset_n low one cycle.
REQ-037 SHALL pass: i_reset asserted between clock edges in LAP_HOLD -> all outputs at reset values before the next edge.
